// File: rtl/gshare_pkg.sv
// Shared defaults and hashing helpers for the gshare global-history unit.
// Helpers work on fixed maximum widths; callers pass the real sizes.
package gshare_pkg;

  localparam int DEF_INDEX_BITS = 13;
  localparam int DEF_HIST_LEN   = 16;
  localparam int DEF_CKPT_DEPTH = 8;
  localparam int DEF_PC_LSB     = 2;
  localparam int MAX_HIST       = 64;
  localparam int MAX_INDEX      = 32;

  function automatic logic [MAX_INDEX-1:0] index_mask(input int index_bits);
    return MAX_INDEX'((64'd1 << index_bits) - 64'd1);
  endfunction

  // Bits above hist_len are zero in h, so the last chunk is implicitly zero-padded.
  function automatic logic [MAX_INDEX-1:0] fold_history(input logic [MAX_HIST-1:0] h,
                                                        input int hist_len,
                                                        input int index_bits);
    logic [MAX_INDEX-1:0] r;
    r = '0;
    for (int c = 0; c < MAX_HIST; c++) begin
      if (c * index_bits < hist_len)
        r = r ^ (MAX_INDEX'(h >> (c * index_bits)) & index_mask(index_bits));
    end
    return r;
  endfunction

  function automatic logic [MAX_INDEX-1:0] gshare_hash(input logic [MAX_HIST-1:0] h,
                                                       input logic [31:0] pc,
                                                       input int hist_len,
                                                       input int index_bits,
                                                       input int pc_lsb);
    return fold_history(h, hist_len, index_bits) ^ (MAX_INDEX'(pc >> pc_lsb) & index_mask(index_bits));
  endfunction

endpackage

// File: rtl/ghr_ckpt_queue.sv
// Circular queue of pre-shift history checkpoints, one per in-flight branch.
// Pointers carry an extra wrap bit; truncate drops everything after the (post-pop) head.
module ghr_ckpt_queue #(
  parameter int HIST_LEN   = 16,
  parameter int CKPT_DEPTH = 8,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [HIST_LEN-1:0] push_hist,
  input  logic                pop,
  input  logic                truncate,
  output logic                full,
  output logic                empty,
  output logic [TAG_W-1:0]    head_tag,
  output logic [TAG_W-1:0]    tail_tag,
  output logic [HIST_LEN-1:0] head_hist,
  output logic [TAG_W:0]      occupancy
);

  logic [TAG_W:0]      head, tail, head_next;
  logic [HIST_LEN-1:0] ckpt [CKPT_DEPTH];

  assign head_next = head + (TAG_W+1)'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) ckpt[i] <= '0;
    end else begin
      head <= head_next;
      if (truncate)
        tail <= head_next;
      else if (push)
        tail <= tail + (TAG_W+1)'(1);
      if (push && !truncate)
        ckpt[tail[TAG_W-1:0]] <= push_hist;
    end
  end

  assign empty     = (head == tail);
  assign full      = (head[TAG_W] != tail[TAG_W]) && (head[TAG_W-1:0] == tail[TAG_W-1:0]);
  assign occupancy = tail - head;
  assign head_tag  = head[TAG_W-1:0];
  assign tail_tag  = tail[TAG_W-1:0];
  assign head_hist = ckpt[head[TAG_W-1:0]];

endmodule

// File: rtl/gshare_spec_history.sv
// Speculative and committed global history for gshare, with per-branch checkpoints
// so a mispredict or flush restores the speculative history in a single cycle.
module gshare_spec_history
  import gshare_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int HIST_LEN   = DEF_HIST_LEN,
  parameter int CKPT_DEPTH = DEF_CKPT_DEPTH,
  parameter int TAG_W      = $clog2(CKPT_DEPTH),
  parameter int PC_LSB     = DEF_PC_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           lookup_pc,
  output logic [INDEX_BITS-1:0] lookup_index,
  input  logic                  predict_valid,
  input  logic                  predict_taken,
  output logic                  predict_ready,
  output logic [TAG_W-1:0]      predict_tag,
  input  logic                  resolve_valid,
  input  logic [TAG_W-1:0]      resolve_tag,
  input  logic                  resolve_taken,
  input  logic                  resolve_mispredict,
  input  logic [31:0]           resolve_pc,
  output logic [INDEX_BITS-1:0] update_index,
  input  logic                  flush,
  output logic [HIST_LEN-1:0]   spec_ghr_out,
  output logic [HIST_LEN-1:0]   commit_ghr_out,
  output logic [TAG_W:0]        occupancy,
  output logic                  order_err
);

  logic [HIST_LEN-1:0]  spec_ghr, commit_ghr, spec_next, commit_next, head_hist;
  logic                 full, empty, legal_resolve, mispredict, push, order_err_q;
  logic [TAG_W-1:0]     head_tag;
  logic [MAX_INDEX-1:0] lookup_hash, update_hash;
  logic                 unused_hash_bits;

  ghr_ckpt_queue #(
    .HIST_LEN   (HIST_LEN),
    .CKPT_DEPTH (CKPT_DEPTH),
    .TAG_W      (TAG_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_hist (spec_ghr),
    .pop       (legal_resolve),
    .truncate  (mispredict | flush),
    .full      (full),
    .empty     (empty),
    .head_tag  (head_tag),
    .tail_tag  (predict_tag),
    .head_hist (head_hist),
    .occupancy (occupancy)
  );

  assign legal_resolve = resolve_valid && !empty && (resolve_tag == head_tag);
  assign mispredict    = legal_resolve && resolve_mispredict;
  // Wrong-path predicts in a restore cycle must neither allocate nor shift.
  assign push          = predict_valid && !full && !mispredict && !flush;
  assign predict_ready = !full;

  always_comb begin
    commit_next = commit_ghr;
    if (legal_resolve) commit_next = {commit_ghr[HIST_LEN-2:0], resolve_taken};
    spec_next = spec_ghr;
    if (flush)
      spec_next = commit_next;
    else if (mispredict)
      spec_next = {head_hist[HIST_LEN-2:0], resolve_taken};
    else if (push)
      spec_next = {spec_ghr[HIST_LEN-2:0], predict_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_ghr    <= '0;
      commit_ghr  <= '0;
      order_err_q <= 1'b0;
    end else begin
      spec_ghr    <= spec_next;
      commit_ghr  <= commit_next;
      order_err_q <= resolve_valid && !legal_resolve;
    end
  end

  assign lookup_hash  = gshare_hash(MAX_HIST'(spec_ghr), lookup_pc, HIST_LEN, INDEX_BITS, PC_LSB);
  assign update_hash  = gshare_hash(MAX_HIST'(head_hist), resolve_pc, HIST_LEN, INDEX_BITS, PC_LSB);
  assign lookup_index = lookup_hash[INDEX_BITS-1:0];
  assign update_index = update_hash[INDEX_BITS-1:0];
  assign unused_hash_bits = ^{lookup_hash, update_hash};

  assign spec_ghr_out   = spec_ghr;
  assign commit_ghr_out = commit_ghr;
  assign order_err      = order_err_q;

endmodule

// File: tb/tb_gshare_spec_history.sv
// Bench for gshare_spec_history: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the history rules.
module tb_gshare_spec_history;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic [12:0] lookup_index;
  logic        predict_valid = 1'b0, predict_taken = 1'b0, predict_ready;
  logic [2:0]  predict_tag;
  logic        resolve_valid = 1'b0, resolve_taken = 1'b0, resolve_mispredict = 1'b0;
  logic [2:0]  resolve_tag = '0;
  logic [31:0] resolve_pc = '0;
  logic [12:0] update_index;
  logic        flush = 1'b0;
  logic [15:0] spec_ghr_out, commit_ghr_out;
  logic [3:0]  occupancy;
  logic        order_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_spec, m_commit;
  logic [15:0] m_q[$];
  int          m_head;
  bit          m_err;

  gshare_spec_history dut (
    .clk                (clk),
    .reset              (reset),
    .lookup_pc          (lookup_pc),
    .lookup_index       (lookup_index),
    .predict_valid      (predict_valid),
    .predict_taken      (predict_taken),
    .predict_ready      (predict_ready),
    .predict_tag        (predict_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
    .resolve_pc         (resolve_pc),
    .update_index       (update_index),
    .flush              (flush),
    .spec_ghr_out       (spec_ghr_out),
    .commit_ghr_out     (commit_ghr_out),
    .occupancy          (occupancy),
    .order_err          (order_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Each history bit i lands on index bit i mod 13.
  function automatic logic [12:0] ref_fold(input logic [15:0] h);
    logic [12:0] r = '0;
    for (int i = 0; i < 16; i++) r[i % 13] = r[i % 13] ^ h[i];
    return r;
  endfunction

  function automatic logic [12:0] ref_index(input logic [15:0] h, input logic [31:0] pc);
    return ref_fold(h) ^ pc[14:2];
  endfunction

  function automatic logic [2:0] m_head_tag();
    return 3'(m_head % 8);
  endfunction

  function automatic logic [2:0] m_tail_tag();
    return 3'((m_head + m_q.size()) % 8);
  endfunction

  task automatic model_reset();
    m_spec = '0; m_commit = '0; m_q.delete(); m_head = 0; m_err = 0;
  endtask

  task automatic model_step(input bit pv, pt, rv, input logic [2:0] rt, input bit rtk, rmis, fl);
    bit full, empty, legal, mis, psh;
    logic [15:0] old_spec, head_h;
    full = (m_q.size() == 8);
    empty = (m_q.size() == 0);
    legal = rv && !empty && (rt == m_head_tag());
    mis = legal && rmis;
    psh = pv && !full && !mis && !fl;
    old_spec = m_spec;
    head_h = empty ? 16'h0 : m_q[0];
    if (legal) begin
      m_commit = {m_commit[14:0], rtk};
      void'(m_q.pop_front());
      m_head++;
    end
    if (psh) begin
      m_q.push_back(old_spec);
      m_spec = {old_spec[14:0], pt};
    end
    if (fl) begin
      m_spec = m_commit;
      m_q.delete();
    end else if (mis) begin
      m_spec = {head_h[14:0], rtk};
      m_q.delete();
    end
    m_err = rv && !legal;
  endtask

  task automatic step(input bit pv, pt, rv, input logic [2:0] rt, input bit rtk, rmis, fl);
    predict_valid = pv; predict_taken = pt;
    resolve_valid = rv; resolve_tag = rt; resolve_taken = rtk; resolve_mispredict = rmis;
    flush = fl;
    @(posedge clk);
    model_step(pv, pt, rv, rt, rtk, rmis, fl);
    #1;
    predict_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    predict_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup_pc = 32'h0000_0040;
    #1;
    checks++; if (lookup_index !== 13'h0010) begin failures++; $display("FAIL reset_lookup_index got=%h exp=%h", lookup_index, 13'h0010); end
    checks++; if (predict_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", predict_ready); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (predict_tag !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", predict_tag); end
    checks++; if (spec_ghr_out !== 16'h0 || commit_ghr_out !== 16'h0) begin failures++; $display("FAIL reset_ghr got=%h/%h exp=0/0", spec_ghr_out, commit_ghr_out); end
    checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL reset_order_err got=%b exp=0", order_err); end
  endtask

  task automatic test_predict_resolve();
    logic [2:0] pattern;
    do_reset();
    pattern = 3'b101;
    for (int i = 0; i < 3; i++) begin
      checks++; if (predict_tag !== 3'(i)) begin failures++; $display("FAIL pr_tag%0d got=%0d exp=%0d", i, predict_tag, i); end
      step(1, pattern[2-i], 0, 3'd0, 0, 0, 0);
    end
    checks++; if (spec_ghr_out !== 16'h0005) begin failures++; $display("FAIL pr_spec got=%h exp=0005", spec_ghr_out); end
    step(0, 0, 1, 3'd0, 1, 0, 0);
    checks++; if (commit_ghr_out !== 16'h0001) begin failures++; $display("FAIL pr_commit got=%h exp=0001", commit_ghr_out); end
    checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL pr_occupancy got=%0d exp=2", occupancy); end
    checks++; if (spec_ghr_out !== 16'h0005) begin failures++; $display("FAIL pr_spec_after_resolve got=%h exp=0005", spec_ghr_out); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 0, 0, 0);
    checks++; if (spec_ghr_out !== 16'h0007) begin failures++; $display("FAIL mp_spec_before got=%h exp=0007", spec_ghr_out); end
    // Same-cycle predict must be dropped as wrong-path.
    step(1, 1, 1, 3'd0, 0, 1, 0);
    checks++; if (spec_ghr_out !== 16'h0000) begin failures++; $display("FAIL mp_spec got=%h exp=0000", spec_ghr_out); end
    checks++; if (commit_ghr_out !== 16'h0000) begin failures++; $display("FAIL mp_commit got=%h exp=0000", commit_ghr_out); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL mp_occupancy got=%0d exp=0", occupancy); end
    checks++; if (predict_tag !== 3'd1) begin failures++; $display("FAIL mp_next_tag got=%0d exp=1", predict_tag); end
  endtask

  task automatic test_full();
    logic [15:0] saved;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1'($urandom_range(1)), 0, 3'd0, 0, 0, 0);
    checks++; if (predict_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", predict_ready); end
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL full_occupancy got=%0d exp=8", occupancy); end
    saved = m_spec;
    step(1, 1, 0, 3'd0, 0, 0, 0);
    checks++; if (spec_ghr_out !== saved) begin failures++; $display("FAIL full_ninth_spec got=%h exp=%h", spec_ghr_out, saved); end
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL full_ninth_occupancy got=%0d exp=8", occupancy); end
    step(0, 0, 1, 3'd0, 1, 0, 0);
    checks++; if (predict_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", predict_ready); end
    checks++; if (occupancy !== 4'd7) begin failures++; $display("FAIL full_occ_after_pop got=%0d exp=7", occupancy); end
    checks++; if (commit_ghr_out !== m_commit) begin failures++; $display("FAIL full_commit got=%h exp=%h", commit_ghr_out, m_commit); end
  endtask

  task automatic test_fold();
    logic [15:0] target;
    do_reset();
    target = 16'hE001;
    for (int i = 15; i >= 0; i--)
      step(1, target[i], m_q.size() > 0, m_head_tag(), 1'($urandom_range(1)), 0, 0);
    lookup_pc = 32'h0;
    resolve_pc = $urandom;
    #1;
    checks++; if (spec_ghr_out !== 16'hE001) begin failures++; $display("FAIL fold_spec got=%h exp=E001", spec_ghr_out); end
    checks++; if (lookup_index !== 13'h0006) begin failures++; $display("FAIL fold_lookup got=%h exp=0006", lookup_index); end
    checks++; if (occupancy !== 4'(m_q.size())) begin failures++; $display("FAIL fold_occupancy got=%0d exp=%0d", occupancy, m_q.size()); end
    if (m_q.size() > 0) begin
      checks++; if (update_index !== ref_index(m_q[0], resolve_pc)) begin failures++; $display("FAIL fold_update got=%h exp=%h", update_index, ref_index(m_q[0], resolve_pc)); end
    end
  endtask

  task automatic test_order_err_flush();
    do_reset();
    step(1, 1, 0, 3'd0, 0, 0, 0);
    step(1, 0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 1, 3'd3, 1, 0, 0);
    checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL oe_pulse got=%b exp=1", order_err); end
    checks++; if (spec_ghr_out !== 16'h0002 || occupancy !== 4'd2 || commit_ghr_out !== 16'h0) begin failures++; $display("FAIL oe_no_change got=%h/%0d/%h exp=0002/2/0000", spec_ghr_out, occupancy, commit_ghr_out); end
    step(0, 0, 0, 3'd0, 0, 0, 0);
    checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL oe_one_cycle got=%b exp=0", order_err); end
    step(1, 1, 0, 3'd0, 0, 0, 1);
    checks++; if (spec_ghr_out !== commit_ghr_out || spec_ghr_out !== 16'h0) begin failures++; $display("FAIL flush_spec got=%h exp=%h", spec_ghr_out, 16'h0); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
    step(1, 1, 0, 3'd0, 0, 0, 0);
    step(1, 1, 0, 3'd0, 0, 0, 0);
    // Flush beats the mispredict restore and picks up the same-cycle commit.
    step(0, 0, 1, m_head_tag(), 1, 1, 1);
    checks++; if (spec_ghr_out !== 16'h0001 || commit_ghr_out !== 16'h0001) begin failures++; $display("FAIL flush_with_resolve got=%h/%h exp=0001/0001", spec_ghr_out, commit_ghr_out); end
    checks++; if (occupancy !== 4'd0 || predict_tag !== 3'd1) begin failures++; $display("FAIL flush_with_resolve_queue got=%0d/%0d exp=0/1", occupancy, predict_tag); end
  endtask

  task automatic test_random();
    bit pv, pt, rv, rtk, rmis, fl;
    logic [2:0] rt;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      pv = ($urandom_range(99) < 60);
      pt = 1'($urandom_range(1));
      rv = ($urandom_range(99) < 45);
      rt = ($urandom_range(99) < 85) ? m_head_tag() : 3'($urandom_range(7));
      rtk = 1'($urandom_range(1));
      rmis = ($urandom_range(99) < 15);
      fl = ($urandom_range(99) < 4);
      lookup_pc = $urandom;
      resolve_pc = $urandom;
      step(pv, pt, rv, rt, rtk, rmis, fl);
      checks++; if (spec_ghr_out !== m_spec) begin failures++; $display("FAIL rnd_spec cyc=%0d got=%h exp=%h", n, spec_ghr_out, m_spec); end
      checks++; if (commit_ghr_out !== m_commit) begin failures++; $display("FAIL rnd_commit cyc=%0d got=%h exp=%h", n, commit_ghr_out, m_commit); end
      checks++; if (occupancy !== 4'(m_q.size())) begin failures++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", n, occupancy, m_q.size()); end
      checks++; if (predict_ready !== (m_q.size() != 8)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, predict_ready, m_q.size() != 8); end
      checks++; if (predict_tag !== m_tail_tag()) begin failures++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", n, predict_tag, m_tail_tag()); end
      checks++; if (order_err !== m_err) begin failures++; $display("FAIL rnd_order_err cyc=%0d got=%b exp=%b", n, order_err, m_err); end
      checks++; if (lookup_index !== ref_index(m_spec, lookup_pc)) begin failures++; $display("FAIL rnd_lookup cyc=%0d got=%h exp=%h", n, lookup_index, ref_index(m_spec, lookup_pc)); end
      if (m_q.size() > 0) begin
        checks++; if (update_index !== ref_index(m_q[0], resolve_pc)) begin failures++; $display("FAIL rnd_update cyc=%0d got=%h exp=%h", n, update_index, ref_index(m_q[0], resolve_pc)); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 1, 3'd5, 0, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (spec_ghr_out !== 16'h0 || commit_ghr_out !== 16'h0) begin failures++; $display("FAIL mid_reset_ghr got=%h/%h exp=0/0", spec_ghr_out, commit_ghr_out); end
    checks++; if (occupancy !== 4'd0 || predict_tag !== 3'd0 || predict_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_queue got=%0d/%0d/%b exp=0/0/1", occupancy, predict_tag, predict_ready); end
    checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL mid_reset_order_err got=%b exp=0", order_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_predict_resolve();
    test_mispredict();
    test_full();
    test_fold();
    test_order_err_flush();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
